ysyx_mem_arbiter: RTL



---
 rtl/ysyx_mem_arbiter_pkg.sv | 22 ++
 rtl/ysyx_mem_arbiter_if.sv | 54 +++++
 rtl/ysyx_arb_picker.sv | 59 +++++
 rtl/ysyx_mem_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM states, bus owner
// encodings and default bus widths.
package ysyx_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  // Which requester currently owns the memory port
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIfu  = 2'd1,
    OwnLsu  = 2'd2
  } owner_e;

endpackage

// File: rtl/ysyx_mem_arbiter_if.sv
// Bus bundle around the arbiter: IFU fetch port, LSU load/store port and the
// single memory port. The master modport is the arbiter's view; the slave
// modport is the view of everything around it (requesters and memory).
interface ysyx_mem_arbiter_if
  import ysyx_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  // IFU side
  logic [ADDR_W-1:0]   ifu_araddr;
  logic                ifu_arvalid;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                ifu_rvalid;

  // LSU side
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_valid;
  logic                lsu_we;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wstrb;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                lsu_rvalid;

  // Memory side
  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    input  ifu_araddr, ifu_arvalid,
    output ifu_rdata, ifu_rvalid,
    input  lsu_addr, lsu_valid, lsu_we, lsu_wdata, lsu_wstrb,
    output lsu_rdata, lsu_rvalid,
    output mem_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    output ifu_araddr, ifu_arvalid,
    input  ifu_rdata, ifu_rvalid,
    output lsu_addr, lsu_valid, lsu_we, lsu_wdata, lsu_wstrb,
    input  lsu_rdata, lsu_rvalid,
    input  mem_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/ysyx_arb_picker.sv
// Grant selection between IFU and LSU. A requester named by the completion
// mask is ignored. Ties go to the LSU by default; with YSYX_ARB_RR_EN defined
// a last_grant register hands a tie to whichever side was not served last.
module ysyx_arb_picker
  import ysyx_mem_arbiter_pkg::*;
(
`ifdef YSYX_ARB_RR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   grant_en,
`endif
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_e mask,
  output owner_e grant
);

  logic ifu_req;
  logic lsu_req;

  assign ifu_req = ifu_valid && (mask != OwnIfu);
  assign lsu_req = lsu_valid && (mask != OwnLsu);

`ifdef YSYX_ARB_RR_EN
  owner_e last_grant_q;

  // Remember who was granted last; reset value makes the LSU win the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OwnIfu;
    end else if (grant_en && (grant != OwnNone)) begin
      last_grant_q <= grant;
    end
  end

  // Tie goes to the side not served last; a lone requester always wins
  always_comb begin
    grant = OwnNone;
    if (ifu_req && lsu_req) begin
      grant = (last_grant_q == OwnLsu) ? OwnIfu : OwnLsu;
    end else if (lsu_req) begin
      grant = OwnLsu;
    end else if (ifu_req) begin
      grant = OwnIfu;
    end
  end
`else
  // Fixed priority: LSU ahead of IFU
  always_comb begin
    grant = OwnNone;
    if (lsu_req) begin
      grant = OwnLsu;
    end else if (ifu_req) begin
      grant = OwnIfu;
    end
  end
`endif

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto one memory port with a
// single outstanding transaction. The winner's request is latched and held
// on the memory port; the response is routed only to the owner.
// Optional build macro: YSYX_ARB_RR_EN (round-robin tie breaking in picker).
module ysyx_mem_arbiter
  import ysyx_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic                clk,
  input logic                rst,
  ysyx_mem_arbiter_if.master bus
);

  localparam int unsigned StrbW = DATA_W / 8;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            mask_q, mask_d;
  owner_e            grant;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]  wstrb_q, wstrb_d;
  logic              complete;

  ysyx_arb_picker u_picker (
`ifdef YSYX_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
    .grant_en  (state_q == StIdle),
`endif
    .ifu_valid (bus.ifu_arvalid),
    .lsu_valid (bus.lsu_valid),
    .mask      (mask_q),
    .grant     (grant)
  );

  // A response completes the transaction in RESP, or in REQ when it arrives
  // together with acceptance. Reset suppresses any pulse in its own cycle.
  assign complete = !rst && bus.mem_rvalid &&
                    ((state_q == StResp) || ((state_q == StReq) && bus.mem_ready));

  // Next-state, latch capture and completion mask
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    // Mask lives for exactly one IDLE cycle after a completion
    mask_d  = OwnNone;
    unique case (state_q)
      StIdle: begin
        if (grant == OwnLsu) begin
          state_d = StReq;
          owner_d = OwnLsu;
          addr_d  = bus.lsu_addr;
          we_d    = bus.lsu_we;
          wdata_d = bus.lsu_wdata;
          wstrb_d = bus.lsu_wstrb;
        end else if (grant == OwnIfu) begin
          // Fetches are always reads
          state_d = StReq;
          owner_d = OwnIfu;
          addr_d  = bus.ifu_araddr;
          we_d    = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
        end
      end
      StReq: begin
        if (bus.mem_ready) begin
          if (bus.mem_rvalid) begin
            state_d = StIdle;
            owner_d = OwnNone;
            mask_d  = owner_q;
          end else begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (bus.mem_rvalid) begin
          state_d = StIdle;
          owner_d = OwnNone;
          mask_d  = owner_q;
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  // State, owner, mask and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      mask_q  <= OwnNone;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Memory request and owner-only response routing
  always_comb begin
    bus.mem_valid  = (state_q == StReq);
    bus.mem_addr   = addr_q;
    bus.mem_we     = we_q;
    bus.mem_wdata  = wdata_q;
    bus.mem_wstrb  = wstrb_q;
    bus.ifu_rvalid = complete && (owner_q == OwnIfu);
    bus.lsu_rvalid = complete && (owner_q == OwnLsu);
    bus.ifu_rdata  = bus.mem_rdata;
    bus.lsu_rdata  = bus.mem_rdata;
  end

endmodule
